// File: rtl/note_judge_ctrl.sv
// Rhythm-game note judge: grades key presses against chart notes within a timing window.
// Optional COMBO_BONUS_EN: hits taken at a pre-increment combo of 10 or more score one extra point.
module note_judge_ctrl #(
  parameter logic [3:0] REST           = 4'd0,
  parameter logic [3:0] EOF            = 4'd15,
  parameter int         WINDOW_CYCLES  = 16,
  parameter int         PERFECT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        note_valid,
  input  logic [3:0]  cur_note,
  input  logic [3:0]  cur_octave,
  input  logic        keypad_valid,
  input  logic [3:0]  keypad_note,
  input  logic [3:0]  keypad_octave,
  output logic [19:0] score,
  output logic [9:0]  combo,
  output logic [9:0]  max_combo,
  output logic        hit_perfect,
  output logic        hit_good,
  output logic        miss,
  output logic        game_over
);

  localparam int            TW     = $clog2(WINDOW_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] T_PERF = TW'(PERFECT_CYCLES);

  typedef enum logic [1:0] {IDLE, JUDGE, LOCKED, END} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    lat_note, lat_note_n, lat_oct, lat_oct_n;
  logic [19:0]   score_n;
  logic [9:0]    combo_n, max_n;
  logic          perf_n, good_n, miss_n;
  logic          match, take_note, hit;
  logic [1:0]    pts;
  logic [20:0]   sum;

  assign match     = keypad_valid && keypad_note == lat_note && keypad_octave == lat_oct;
  assign game_over = (state == END);

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    lat_note_n = lat_note;
    lat_oct_n  = lat_oct;
    score_n    = score;
    combo_n    = combo;
    max_n      = max_combo;
    perf_n     = 1'b0;
    good_n     = 1'b0;
    miss_n     = 1'b0;
    take_note  = 1'b0;
    hit        = 1'b0;
    pts        = 2'd0;
    sum        = 21'd0;

    case (state)
      IDLE, LOCKED: take_note = note_valid;
      JUDGE: begin
        timer_n   = timer + 1'b1;
        take_note = note_valid;
        if (match) begin
          hit     = 1'b1;
          perf_n  = (timer < T_PERF);
          good_n  = !(timer < T_PERF);
          state_n = LOCKED;
        end else if (note_valid || timer == T_LAST) begin
          miss_n  = 1'b1;
          combo_n = 10'd0;
          state_n = IDLE;
        end
      end
      default: ;
    endcase

    if (hit) begin
      pts = perf_n ? 2'd2 : 2'd1;
`ifdef COMBO_BONUS_EN
      if (combo >= 10'd10) pts = pts + 2'd1;
`endif
      sum     = {1'b0, score} + 21'(pts);
      score_n = sum[20] ? 20'hFFFFF : sum[19:0];
      combo_n = (combo == 10'd1023) ? combo : combo + 10'd1;
      if (combo_n > max_combo) max_n = combo_n;
    end

    // A new note overrides the post-judge state even on the deciding edge
    if (take_note) begin
      if (cur_note == EOF) begin
        state_n = END;
      end else if (cur_note == REST) begin
        state_n = IDLE;
      end else begin
        lat_note_n = cur_note;
        lat_oct_n  = cur_octave;
        timer_n    = '0;
        state_n    = JUDGE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      lat_note    <= 4'd0;
      lat_oct     <= 4'd0;
      score       <= 20'd0;
      combo       <= 10'd0;
      max_combo   <= 10'd0;
      hit_perfect <= 1'b0;
      hit_good    <= 1'b0;
      miss        <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      lat_note    <= lat_note_n;
      lat_oct     <= lat_oct_n;
      score       <= score_n;
      combo       <= combo_n;
      max_combo   <= max_n;
      hit_perfect <= perf_n;
      hit_good    <= good_n;
      miss        <= miss_n;
    end
  end

endmodule

// File: tb/tb_note_judge_ctrl.sv
// Randomized + directed bench for note_judge_ctrl against a pending-note reference model.
module tb_note_judge_ctrl;
  localparam int W = 16, P = 4;

  logic        clk = 0, rst = 0;
  logic        note_valid = 0, keypad_valid = 0;
  logic [3:0]  cur_note = 0, cur_octave = 0, keypad_note = 0, keypad_octave = 0;
  logic [19:0] score;
  logic [9:0]  combo, max_combo;
  logic        hit_perfect, hit_good, miss, game_over;

  note_judge_ctrl #(.REST(4'd0), .EOF(4'd15), .WINDOW_CYCLES(W), .PERFECT_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .cur_note(cur_note), .cur_octave(cur_octave),
    .keypad_valid(keypad_valid), .keypad_note(keypad_note), .keypad_octave(keypad_octave),
    .score(score), .combo(combo), .max_combo(max_combo), .hit_perfect(hit_perfect),
    .hit_good(hit_good), .miss(miss), .game_over(game_over));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    tests++;
    if (obs != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: one optional pending note with its age, plus the running tallies
  bit         m_act, m_over, m_p, m_g, m_m;
  int         m_age, m_score, m_combo, m_max;
  logic [3:0] m_n, m_o;

  function automatic void m_reset();
    m_act = 0; m_over = 0; m_p = 0; m_g = 0; m_m = 0;
    m_age = 0; m_score = 0; m_combo = 0; m_max = 0; m_n = 0; m_o = 0;
  endfunction

  function automatic void m_credit(bit perfect);
    int pts;
    pts = perfect ? 2 : 1;
`ifdef COMBO_BONUS_EN
    if (m_combo >= 10) pts++;
`endif
    m_score = (m_score + pts > 'hFFFFF) ? 'hFFFFF : m_score + pts;
    m_combo = (m_combo >= 1023) ? 1023 : m_combo + 1;
    if (m_combo > m_max) m_max = m_combo;
    if (perfect) m_p = 1; else m_g = 1;
  endfunction

  function automatic void m_step(bit nv, logic [3:0] cn, logic [3:0] co,
                                 bit kv, logic [3:0] kn, logic [3:0] ko);
    m_p = 0; m_g = 0; m_m = 0;
    if (m_over) return;
    if (m_act) begin
      if (kv && kn == m_n && ko == m_o) begin
        m_credit(m_age < P);
        m_act = 0;
      end else if (nv || m_age == W - 1) begin
        m_m = 1; m_combo = 0; m_act = 0;
      end else m_age++;
    end
    if (nv) begin
      if (cn == 4'd15) begin m_over = 1; m_act = 0; end
      else if (cn != 4'd0) begin m_act = 1; m_age = 0; m_n = cn; m_o = co; end
    end
  endfunction

  task automatic check_all(input string pfx);
    chk({pfx, "_score"}, int'(score), m_score);
    chk({pfx, "_combo"}, int'(combo), m_combo);
    chk({pfx, "_max"}, int'(max_combo), m_max);
    chk({pfx, "_pulses"}, int'({hit_perfect, hit_good, miss}), int'({m_p, m_g, m_m}));
    chk({pfx, "_over"}, int'(game_over), int'(m_over));
  endtask

  task automatic cyc(input bit nv, input logic [3:0] cn, input logic [3:0] co,
                     input bit kv, input logic [3:0] kn, input logic [3:0] ko);
    @(negedge clk);
    note_valid = nv; cur_note = cn; cur_octave = co;
    keypad_valid = kv; keypad_note = kn; keypad_octave = ko;
    m_step(nv, cn, co, kv, kn, ko);
    @(posedge clk); #1;
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(posedge clk); #2;
    rst = 1; m_reset();
    #1 check_all("rst");
    @(negedge clk); rst = 0;
  endtask

  initial begin
    m_reset();
    #1 rst = 1;
    #1 check_all("por");
    @(negedge clk); rst = 0;

    // perfect hit at timer 2
    cyc(1, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 4);
    chk("r036_perfect", int'(hit_perfect), 1);
    chk("r036_score", int'(score), 2);
    idle(2);

    // good hit at timer 8 with the key held for 5 cycles
    cyc(1, 1, 4, 0, 0, 0);
    idle(8);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 4);
    chk("r037_score", int'(score), 3);
    chk("r037_max", int'(max_combo), 2);

    // unanswered note misses on the 16th cycle
    cyc(1, 2, 3, 0, 0, 0);
    for (int i = 0; i < W - 1; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("r038_nomiss_yet", int'(miss), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("r038_miss", int'(miss), 1);
    chk("r038_max", int'(max_combo), 2);

    // wrong key, then a new note at timer 5; new note hit at its timer 0 is perfect
    cyc(1, 2, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 3, 3);
    cyc(1, 3, 4, 1, 3, 3);
    chk("r039_miss", int'(miss), 1);
    cyc(0, 0, 0, 1, 3, 4);
    chk("r039_perfect", int'(hit_perfect), 1);

    // REST is never judged
    cyc(1, 0, 4, 0, 0, 0);
    for (int i = 0; i < W + 2; i++) cyc(0, 0, 0, 1, 0, 4);

    // reset while a note is pending
    cyc(1, 2, 4, 0, 0, 0);
    idle(3);
    async_reset();
    idle(W + 2);

    // 11 consecutive perfect hits from reset
    async_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(1, 1, 3, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 3);
    end
`ifdef COMBO_BONUS_EN
    chk("r041_score", int'(score), 23);
`else
    chk("r041_score", int'(score), 22);
`endif
    chk("r041_combo", int'(combo), 11);

    // randomized play
    for (int i = 0; i < 1500; i++) begin
      bit nv, kv;
      logic [3:0] cn, co, kn, ko;
      nv = ($urandom_range(0, 9) == 0);
      cn = 4'($urandom_range(0, 3));
      co = 4'($urandom_range(3, 4));
      kv = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) begin kn = m_n; ko = m_o; end
      else begin kn = 4'($urandom_range(1, 3)); ko = 4'($urandom_range(3, 4)); end
      cyc(nv, cn, co, kv, kn, ko);
    end

    // end of song freezes everything
    cyc(1, 15, 0, 0, 0, 0);
    chk("r040_over", int'(game_over), 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 4, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 4);
    end
    async_reset();
    chk("r040_rst_over", int'(game_over), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
